// File: rtl/mutex_arbiter_pkg.sv
// Shared types and helpers for the mutex arbiter: FSM state encoding and hold-counter sizing.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mutex_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

  // Hold counter must represent 0..max_hold; keep at least one bit when the limit is off.
  function automatic int hold_cnt_w(input int max_hold);
    int w;
    w = $clog2(max_hold + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mutex_arbiter_if.sv
// Request/grant bundle between requesting agents (slave side) and the arbiter (master side).
// Latency: wires only.
// Backpressure: req is held by an agent for as long as it wants or uses the resource.
interface mutex_arbiter_if
  import mutex_arbiter_pkg::*;
#(
  parameter int N = 8,
  parameter int W = $clog2(N)
);
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic         grantValid;
  logic [W-1:0] grantId;
  logic         revoked;

  modport master (input req, output grant, output grantValid, output grantId, output revoked);
  modport slave  (output req, input grant, input grantValid, input grantId, input revoked);
endinterface

// File: rtl/mutex_arbiter_pick.sv
// Combinational masked priority encoder: first set bit scanning downward from ptr_i-1 with wrap.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; vld_o low when the eligible vector is empty.
module mutex_pick
  import mutex_arbiter_pkg::*;
#(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] elig_i,
  input  logic [W-1:0] ptr_i,
  output logic         vld_o,
  output logic [W-1:0] idx_o
);

  int cand;

  // Scan ptr-1, ptr-2, ..., 0, N-1, ..., ptr; ptr=0 degenerates to highest-index-wins.
  always_comb begin
    vld_o = 1'b0;
    idx_o = '0;
    cand  = 0;
    for (int k = 1; k <= N; k++) begin
      cand = int'(ptr_i) + N - k;
      if (cand >= N) cand = cand - N;
      if (!vld_o && elig_i[cand]) begin
        vld_o = 1'b1;
        idx_o = W'(cand);
      end
    end
  end

endmodule

// File: rtl/mutex_arbiter.sv
// Grant/hold/release mutex over N requesters with guard gap, optional hold limit and (MUTEX_ARBITER_ROUND_ROBIN_EN) round robin.
// Latency: req sampled high in IDLE -> registered grant after 1 edge; release -> 2 grant-free cycles before next owner.
// Backpressure: non-owner requests are not queued; they are simply re-evaluated on the next IDLE edge.
module mutex_arbiter
  import mutex_arbiter_pkg::*;
#(
  parameter int N        = 8,
  parameter int W        = $clog2(N),
  parameter int MAX_HOLD = 0
) (
  input  logic                   clock,
  input  logic                   resetN,
  mutex_arbiter_if.master        bus
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_GRANT = GRANT;
  localparam logic [1:0] S_GAP   = GAP;

  localparam int            HW        = hold_cnt_w(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [W-1:0]  gid_q,   gid_d;
  logic          vld_q,   vld_d;
  logic          rev_q,   rev_d;
  logic [HW-1:0] hold_q,  hold_d;
  logic [N-1:0]  block_q, block_d;

  logic [N-1:0]  elig;
  logic          pick_vld;
  logic [W-1:0]  pick_idx;
  logic [W-1:0]  pick_ptr;

  assign elig = bus.req & ~block_q;

  mutex_pick #(.N(N), .W(W)) u_pick (
    .elig_i (elig),
    .ptr_i  (pick_ptr),
    .vld_o  (pick_vld),
    .idx_o  (pick_idx)
  );

`ifdef MUTEX_ARBITER_ROUND_ROBIN_EN
  logic [W-1:0] rr_q, rr_d;

  assign rr_d     = (state_q == S_IDLE && pick_vld) ? pick_idx : rr_q;
  assign pick_ptr = rr_q;

  // Pointer tracks the most recent new owner so the search starts just below it.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) rr_q <= '0;
    else         rr_q <= rr_d;
  end
`else
  assign pick_ptr = '0;
`endif

  // Arbitration FSM: IDLE picks, GRANT holds until release or limit, GAP forces one dead cycle.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gid_d   = gid_q;
    vld_d   = vld_q;
    rev_d   = 1'b0;
    hold_d  = hold_q;
    block_d = block_q & bus.req;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          state_d = S_GRANT;
          grant_d = N'(1) << pick_idx;
          gid_d   = pick_idx;
          vld_d   = 1'b1;
          hold_d  = '0;
        end
      end
      S_GRANT: begin
        if (!bus.req[gid_q]) begin
          // Voluntary release wins over a coincident limit hit.
          state_d = S_GAP;
          grant_d = '0;
          gid_d   = '0;
          vld_d   = 1'b0;
        end else if ((MAX_HOLD > 0) && (hold_q == HOLD_LAST)) begin
          state_d        = S_GAP;
          grant_d        = '0;
          gid_d          = '0;
          vld_d          = 1'b0;
          rev_d          = 1'b1;
          block_d[gid_q] = 1'b1;
        end else if (hold_q != '1) begin
          hold_d = hold_q + HW'(1);
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        gid_d   = '0;
        vld_d   = 1'b0;
      end
    endcase
  end

  // All outputs are registered; reset clears them immediately.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      gid_q   <= '0;
      vld_q   <= 1'b0;
      rev_q   <= 1'b0;
      hold_q  <= '0;
      block_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gid_q   <= gid_d;
      vld_q   <= vld_d;
      rev_q   <= rev_d;
      hold_q  <= hold_d;
      block_q <= block_d;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.grantValid = vld_q;
  assign bus.grantId    = gid_q;
  assign bus.revoked    = rev_q;

endmodule
